tlb_cmd_ctrl: RTL and testbench
===============================

TLB_CMD_CTRL -- requirements
Module: tlb_cmd_ctrl

Interface
REQ-001 Parameter TLBNUM, default 16: number of TLB entries; IW = log2(TLBNUM).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high.
REQ-005 cmd_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal.
REQ-006 cmd_invop  in  5  INVTLB op, used only when cmd_op=4.
REQ-007 cmd_asid / cmd_vppn  in  10 / 19  CSR ASID and EHI.VPPN, used by SRCH and INV.
REQ-008 cmd_index  in  IW  CSR TLBIDX.index for RD and WR.
REQ-009 cmd_wdata  in  bundle  e, ps[6], g, ppn0/plv0/mat0/d0/v0, ppn1/plv1/mat1/d1/v1, used by WR and FILL.
REQ-010 tlb_s_vppn, tlb_s_asid, tlb_s_va_bit12  out  19, 10, 1  drive the TLB search port 1.
REQ-011 tlb_s_found, tlb_s_index  in  1, IW  search result.
REQ-012 tlb_we, tlb_w_index, tlb_w_*  out  1, IW, bundle  TLB write port.
REQ-013 tlb_r_index  out  IW; tlb_r_*  in  bundle  TLB read port.
REQ-014 tlb_invtlb_valid, tlb_invtlb_op  out  1, 5  TLB invalidate port.
REQ-015 done  out  1  one-cycle completion pulse; done_op  out  3  the completed op.
REQ-016 rsp_found, rsp_index, rsp_err  out  1, IW, 1  SRCH result and illegal-op flag.
REQ-017 rsp_rdata  out  bundle  registered TLB entry (same fields as cmd_wdata) for RD.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-019 On handshake in IDLE, the block SHALL latch op, invop, asid, vppn, index and wdata, then go to EXEC.
REQ-020 EXEC SHALL last exactly one cycle and then go to RESP; RESP SHALL last one cycle and then go to IDLE.
REQ-021 done SHALL be 1 only in RESP; done_op SHALL equal the latched op.
REQ-022 Accept-to-done latency SHALL be 2 cycles; back-to-back throughput SHALL be one command per 3 cycles.
REQ-023 SRCH: in EXEC, drive tlb_s_vppn/asid from the latch with va_bit12=0; at the end of EXEC, register found and index into rsp_found/rsp_index.
REQ-024 rsp_index SHALL be 0 when found=0.
REQ-025 RD: in EXEC, drive tlb_r_index = latched index; at the end of EXEC, register the tlb_r_* fields into rsp_rdata.
REQ-026 WR: tlb_we SHALL be 1 only in EXEC, with tlb_w_index = latched index and tlb_w_* = latched wdata.
REQ-027 FILL: same as WR, except tlb_w_index SHALL be the fill counter value sampled at handshake.
REQ-028 Fill counter: IW bits, increments every cycle, wraps from TLBNUM-1 to 0, resets to 0.
REQ-029 INV: tlb_invtlb_valid SHALL be 1 only in EXEC, with tlb_invtlb_op = latched invop.
REQ-030 Illegal op (5-7): no TLB port activity; rsp_err=1 in RESP; otherwise rsp_err=0.
REQ-031 tlb_we and tlb_invtlb_valid SHALL never be high in the same cycle, and never outside EXEC.
REQ-032 rsp_found/rsp_index/rsp_rdata SHALL hold their value until the next SRCH/RD completes.
REQ-033 cmd_valid held high during EXEC/RESP SHALL not be accepted; inputs may change freely after handshake.

Reset
REQ-034 Reset SHALL force IDLE and fill counter=0; it takes priority over any handshake in the same cycle.
REQ-035 Reset values: cmd_ready=0 while reset is high, then 1 in the first cycle after reset; done=0, done_op=0, tlb_we=0, tlb_invtlb_valid=0, rsp_found=0, rsp_index=0, rsp_err=0, rsp_rdata=0.
REQ-036 Reset asserted during EXEC SHALL drop tlb_we/tlb_invtlb_valid in the next cycle; no done pulse is issued for the aborted command.

Verification
REQ-037 Three cycles after reset release, issue WR index=5, vppn=0x1234, asid=3, g=0, e=1 -> tlb_we=1 with w_index=5 for exactly 1 cycle; done at accept+2.
REQ-038 Then SRCH vppn=0x1234, asid=3 -> rsp_found=1, rsp_index=5 with done; SRCH asid=4 -> rsp_found=0, rsp_index=0.
REQ-039 RD index=5 -> rsp_rdata.vppn=0x1234, asid=3, e=1; RD of an unwritten index -> e=0.
REQ-040 FILL accepted in the 9th cycle after reset -> tlb_w_index=8 (counter sampled at handshake).
REQ-041 INV invop=5, asid=3, vppn=0x1234 -> tlb_invtlb_valid=1, op=5 for one cycle; a following SRCH -> found=0.
REQ-042 cmd_op=6 -> no we/invtlb, done with rsp_err=1.
REQ-043 Assert reset in the WR EXEC cycle -> no done pulse, FSM in IDLE, cmd_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/tlb_cmd_ctrl.sv
// TLB command sequencer: accepts one SRCH/RD/WR/FILL/INV command at a time and runs it IDLE -> EXEC -> RESP.
// Entry layout {vppn[18:0], asid[9:0], e, ps[5:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}.
module tlb_cmd_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM),
    localparam int WD_W   = 60,
    localparam int ENT_W  = 89
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [4:0]       cmd_invop_i,
    input  logic [9:0]       cmd_asid_i,
    input  logic [18:0]      cmd_vppn_i,
    input  logic [IW-1:0]    cmd_index_i,
    input  logic [WD_W-1:0]  cmd_wdata_i,
    output logic [18:0]      tlb_s_vppn_o,
    output logic [9:0]       tlb_s_asid_o,
    output logic             tlb_s_va_bit12_o,
    input  logic             tlb_s_found_i,
    input  logic [IW-1:0]    tlb_s_index_i,
    output logic             tlb_we_o,
    output logic [IW-1:0]    tlb_w_index_o,
    output logic [ENT_W-1:0] tlb_w_entry_o,
    output logic [IW-1:0]    tlb_r_index_o,
    input  logic [ENT_W-1:0] tlb_r_entry_i,
    output logic             tlb_invtlb_valid_o,
    output logic [4:0]       tlb_invtlb_op_o,
    output logic             done_o,
    output logic [2:0]       done_op_o,
    output logic             rsp_found_o,
    output logic [IW-1:0]    rsp_index_o,
    output logic             rsp_err_o,
    output logic [ENT_W-1:0] rsp_rdata_o
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ready_q;
    logic [2:0]        op_q;
    logic [4:0]        invop_q;
    logic [9:0]        asid_q;
    logic [18:0]       vppn_q;
    logic [IW-1:0]     index_q;
    logic [WD_W-1:0]   wdata_q;
    logic [IW-1:0]     fill_cnt_q;
    logic [IW-1:0]     fill_idx_q;
    logic              found_q;
    logic [IW-1:0]     sidx_q;
    logic [ENT_W-1:0]  rdata_q;
    logic              accept;

    assign accept = cmd_valid_i & ready_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered so it stays low for the first cycle after reset is released
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ready_q    <= 1'b0;
            fill_cnt_q <= {IW{1'b0}};
            fill_idx_q <= {IW{1'b0}};
            op_q       <= 3'd0;
            invop_q    <= 5'd0;
            asid_q     <= 10'd0;
            vppn_q     <= 19'd0;
            index_q    <= {IW{1'b0}};
            wdata_q    <= {WD_W{1'b0}};
        end else begin
            ready_q    <= (state_d == IDLE);
            fill_cnt_q <= (fill_cnt_q == IW'(TLBNUM - 1)) ? {IW{1'b0}} : fill_cnt_q + 1'b1;
            if (accept) begin
                fill_idx_q <= fill_cnt_q;
                op_q       <= cmd_op_i;
                invop_q    <= cmd_invop_i;
                asid_q     <= cmd_asid_i;
                vppn_q     <= cmd_vppn_i;
                index_q    <= cmd_index_i;
                wdata_q    <= cmd_wdata_i;
            end
        end
    end

    // Search and read results captured at the end of EXEC; held until the next SRCH/RD
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            found_q <= 1'b0;
            sidx_q  <= {IW{1'b0}};
            rdata_q <= {ENT_W{1'b0}};
        end else if (state_q == EXEC) begin
            if (op_q == OP_SRCH) begin
                found_q <= tlb_s_found_i;
                sidx_q  <= tlb_s_found_i ? tlb_s_index_i : {IW{1'b0}};
            end
            if (op_q == OP_RD) begin
                rdata_q <= tlb_r_entry_i;
            end
        end
    end

    // Output decode from the state register and latched command
    always_comb begin
        tlb_we_o           = 1'b0;
        tlb_invtlb_valid_o = 1'b0;
        done_o             = 1'b0;
        done_op_o          = 3'd0;
        rsp_err_o          = 1'b0;
        case (state_q)
            EXEC: begin
                tlb_we_o           = (op_q == OP_WR) || (op_q == OP_FILL);
                tlb_invtlb_valid_o = (op_q == OP_INV);
            end
            RESP: begin
                done_o    = 1'b1;
                done_op_o = op_q;
                rsp_err_o = (op_q > OP_INV);
            end
            default: begin
                tlb_we_o = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o      = ready_q;
    assign tlb_s_vppn_o     = vppn_q;
    assign tlb_s_asid_o     = asid_q;
    assign tlb_s_va_bit12_o = 1'b0;
    assign tlb_w_index_o    = (op_q == OP_FILL) ? fill_idx_q : index_q;
    assign tlb_w_entry_o    = {vppn_q, asid_q, wdata_q};
    assign tlb_r_index_o    = index_q;
    assign tlb_invtlb_op_o  = invop_q;
    assign rsp_found_o      = found_q;
    assign rsp_index_o      = sidx_q;
    assign rsp_rdata_o      = rdata_q;

endmodule

// File: tb/tb_tlb_cmd_ctrl.sv
// Scoreboard bench for tlb_cmd_ctrl with a behavioural TLB array on the search/read/write/invalidate ports.
module tb_tlb_cmd_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [4:0]  cmd_invop = 5'd0;
    logic [9:0]  cmd_asid = 10'd0;
    logic [18:0] cmd_vppn = 19'd0;
    logic [3:0]  cmd_index = 4'd0;
    logic [59:0] cmd_wdata = 60'd0;
    logic [18:0] s_vppn;
    logic [9:0]  s_asid;
    logic        s_va12;
    logic        s_found;
    logic [3:0]  s_index;
    logic        we;
    logic [3:0]  w_index;
    logic [88:0] w_entry;
    logic [3:0]  r_index;
    logic [88:0] r_entry;
    logic        inv_valid;
    logic [4:0]  inv_op;
    logic        done;
    logic [2:0]  done_op;
    logic        rsp_found;
    logic [3:0]  rsp_index;
    logic        rsp_err;
    logic [88:0] rsp_rdata;

    always #5 clk = ~clk;

    tlb_cmd_ctrl #(.TLBNUM(N)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_invop_i(cmd_invop), .cmd_asid_i(cmd_asid),
        .cmd_vppn_i(cmd_vppn), .cmd_index_i(cmd_index), .cmd_wdata_i(cmd_wdata),
        .tlb_s_vppn_o(s_vppn), .tlb_s_asid_o(s_asid), .tlb_s_va_bit12_o(s_va12),
        .tlb_s_found_i(s_found), .tlb_s_index_i(s_index),
        .tlb_we_o(we), .tlb_w_index_o(w_index), .tlb_w_entry_o(w_entry),
        .tlb_r_index_o(r_index), .tlb_r_entry_i(r_entry),
        .tlb_invtlb_valid_o(inv_valid), .tlb_invtlb_op_o(inv_op),
        .done_o(done), .done_op_o(done_op),
        .rsp_found_o(rsp_found), .rsp_index_o(rsp_index),
        .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata)
    );

    // Behavioural TLB: bit 59 = e, bit 52 = g, [69:60] = asid, [88:70] = vppn
    logic [88:0] mem [N] = '{default: 89'd0};
    logic        m_found;
    logic [3:0]  m_idx;

    always_comb begin
        m_found = 1'b0;
        m_idx   = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (mem[i][59] && mem[i][88:70] == s_vppn && (mem[i][52] || mem[i][69:60] == s_asid)) begin
                m_found = 1'b1;
                m_idx   = 4'(i);
            end
        end
    end
    assign s_found = m_found;
    assign s_index = m_idx;
    assign r_entry = mem[r_index];

    always @(posedge clk) begin
        if (we) mem[w_index] <= w_entry;
        if (inv_valid && inv_op == 5'd5) begin
            for (int i = 0; i < N; i++) begin
                if (!mem[i][52] && mem[i][69:60] == s_asid && mem[i][88:70] == s_vppn) mem[i][59] <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic        found;
        logic [3:0]  sidx;
        logic [88:0] rd;
        logic [88:0] rmask;
        int          at;
    } rsp_t;
    typedef struct { logic [3:0] idx; int at; } wr_t;
    typedef struct { logic [4:0] op;  int at; } inv_t;

    rsp_t rq[$];
    wr_t  wq[$];
    inv_t iq[$];

    int checks = 0;
    int errors = 0;
    logic       last_found = 1'b0;
    logic [3:0] last_sidx = 4'd0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every TLB-port pulse and every done pulse against the queues
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        inv_t v;
        if (we && inv_valid) chk("we_and_inv", 128'd1, 128'd0);
        if (we) begin
            if (wq.size() == 0) chk("unexpected_we", 128'(w_index), 128'hFFFF);
            else begin
                w = wq.pop_front();
                chk("w_index", 128'(w_index), 128'(w.idx));
                chk("we_cycle", 128'(cyc), 128'(w.at));
            end
        end
        if (inv_valid) begin
            if (iq.size() == 0) chk("unexpected_inv", 128'(inv_op), 128'hFFFF);
            else begin
                v = iq.pop_front();
                chk("inv_op", 128'(inv_op), 128'(v.op));
                chk("inv_cycle", 128'(cyc), 128'(v.at));
            end
        end
        if (done) begin
            if (rq.size() == 0) chk("unexpected_done", 128'(done_op), 128'hFFFF);
            else begin
                r = rq.pop_front();
                chk("done_op", 128'(done_op), 128'(r.op));
                chk("done_cycle", 128'(cyc), 128'(r.at));
                chk("rsp_err", 128'(rsp_err), 128'(r.err));
                chk("rsp_found", 128'(rsp_found), 128'(r.found));
                chk("rsp_index", 128'(rsp_index), 128'(r.sidx));
                chk("va_bit12", 128'(s_va12), 128'd0);
                if (r.rmask != 89'd0) chk("rsp_rdata", 128'(rsp_rdata & r.rmask), 128'(r.rd & r.rmask));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 128'(cmd_ready), 128'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] asid,
                         input logic [18:0] vppn, input logic [3:0] idx, input logic [59:0] wd,
                         input bit has_done, input logic ef, input logic [3:0] es,
                         input logic [3:0] ew, input logic [88:0] erd, input logic [88:0] emask);
        int acc;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_invop = invop; cmd_asid = asid;
        cmd_vppn = vppn; cmd_index = idx; cmd_wdata = wd;
        acc = cyc;
        if (op == 3'd2 || op == 3'd3) wq.push_back('{ew, acc + 1});
        if (op == 3'd4) iq.push_back('{invop, acc + 1});
        if (op == 3'd0) begin last_found = ef; last_sidx = es; end
        if (has_done) rq.push_back('{op, (op > 3'd4), last_found, last_sidx, erd, emask, acc + 2});
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_invop = 5'($urandom); cmd_asid = 10'($urandom);
        cmd_vppn = 19'($urandom); cmd_index = 4'($urandom); cmd_wdata = 60'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(cmd_ready), 128'd0);
        chk("rst_done", 128'({done, done_op}), 128'd0);
        chk("rst_we_inv", 128'({we, inv_valid}), 128'd0);
        chk("rst_rsp", 128'({rsp_found, rsp_index, rsp_err}), 128'd0);
        chk("rst_rdata", 128'(rsp_rdata), 128'd0);
        reset = 1'b0;
        last_found = 1'b0;
        last_sidx = 4'd0;
        @(negedge clk);
        chk("ready_after_rst", 128'(cmd_ready), 128'd1);
    endtask

    logic [59:0] wd_a, wd_b, wd_f;
    logic [88:0] all1;
    int acc;

    initial begin
        // e, ps, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1
        wd_a = {1'b1, 6'd12, 1'b0, 20'h00abc, 2'd0, 2'd1, 1'b1, 1'b1, 20'h00abd, 2'd3, 2'd1, 1'b0, 1'b1};
        wd_b = {1'b1, 6'd12, 1'b1, 20'h01234, 2'd1, 2'd1, 1'b0, 1'b1, 20'h01235, 2'd1, 2'd1, 1'b0, 1'b1};
        wd_f = {1'b1, 6'd21, 1'b0, 20'h55555, 2'd2, 2'd0, 1'b1, 1'b0, 20'haaaaa, 2'd0, 2'd2, 1'b0, 1'b1};
        all1 = {89{1'b1}};
        @(negedge clk);
        do_reset();
        @(negedge clk);
        // WR index 5 in the third cycle after release
        issue(3'd2, 5'd0, 10'd3, 19'h1234, 4'd5, wd_a, 1'b1, 1'b0, 4'd0, 4'd5, 89'd0, 89'd0);
        issue(3'd0, 5'd0, 10'd3, 19'h1234, 4'd0, 60'd0, 1'b1, 1'b1, 4'd5, 4'd0, 89'd0, 89'd0);
        issue(3'd0, 5'd0, 10'd4, 19'h1234, 4'd0, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, 89'd0, 89'd0);
        issue(3'd1, 5'd0, 10'd0, 19'd0, 4'd5, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, {19'h1234, 10'd3, wd_a}, all1);
        issue(3'd1, 5'd0, 10'd0, 19'd0, 4'd9, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, 89'd0, {29'd0, 1'b1, 59'd0});
        issue(3'd4, 5'd5, 10'd3, 19'h1234, 4'd0, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, 89'd0, 89'd0);
        issue(3'd0, 5'd0, 10'd3, 19'h1234, 4'd0, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, 89'd0, 89'd0);
        issue(3'd6, 5'd5, 10'd3, 19'h1234, 4'd5, wd_a, 1'b1, 1'b0, 4'd0, 4'd0, 89'd0, 89'd0);
        // Global entry, then a SRCH with valid held high: accepted once per 3 cycles
        issue(3'd2, 5'd0, 10'd7, 19'h0777, 4'd2, wd_b, 1'b1, 1'b0, 4'd0, 4'd2, 89'd0, 89'd0);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_vppn = 19'h0777; cmd_asid = 10'd9;
        acc = cyc;
        last_found = 1'b1;
        last_sidx = 4'd2;
        rq.push_back('{3'd0, 1'b0, 1'b1, 4'd2, 89'd0, 89'd0, acc + 2});
        rq.push_back('{3'd0, 1'b0, 1'b1, 4'd2, 89'd0, 89'd0, acc + 5});
        repeat (4) @(negedge clk);
        cmd_valid = 1'b0;
        // Reset asserted in the WR EXEC cycle: write pulse seen, no done
        issue(3'd2, 5'd0, 10'd1, 19'h2222, 4'd11, wd_a, 1'b0, 1'b0, 4'd0, 4'd11, 89'd0, 89'd0);
        do_reset();
        // FILL accepted in the 9th cycle after release samples counter value 8
        repeat (7) @(negedge clk);
        issue(3'd3, 5'd0, 10'd1, 19'h3333, 4'd0, wd_f, 1'b1, 1'b0, 4'd0, 4'd8, 89'd0, 89'd0);
        issue(3'd1, 5'd0, 10'd0, 19'd0, 4'd8, 60'd0, 1'b1, 1'b0, 4'd0, 4'd0, {19'h3333, 10'd1, wd_f}, all1);
        repeat (6) @(negedge clk);
        chk("rq_drained", 128'(rq.size()), 128'd0);
        chk("wq_drained", 128'(wq.size()), 128'd0);
        chk("iq_drained", 128'(iq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
